// File: rtl/cos_lut_pkg.sv
// Shared constants and types for the cosine-LUT arbiter slice.
// Optional statistics are enabled with the COS_ARB_STATS_EN macro (see cos_lut_arbiter).
package cos_lut_pkg;

    localparam int XW   = 14;
    localparam int YW   = 16;
    // Tag id width sized for the largest supported requester count (8).
    localparam int ID_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arbState_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/cos_lut_tag_pipe.sv
// LAT-deep shift register of {valid, id} tags that mirrors the evaluator latency
// and decodes the tag leaving the last stage into a one-hot requester strobe.
module cos_lut_tag_pipe
    import cos_lut_pkg::*;
#(
    parameter int LAT  = 1,
    parameter int NREQ = 4
)(
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iLoad_valid,
    input  logic [ID_W-1:0] iLoad_id,
    output logic [NREQ-1:0] oHit,
    output logic            oBusy
);

    tag_t [LAT-1:0] r_stage;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_stage <= '0;
        end else begin
            r_stage[0].valid <= iLoad_valid;
            r_stage[0].id    <= iLoad_id;
            for (int s = 1; s < LAT; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    always_comb begin
        oHit  = '0;
        oBusy = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            oHit[k] = r_stage[LAT-1].valid && (r_stage[LAT-1].id == ID_W'(k));
        end
        for (int s = 0; s < LAT; s++) begin
            oBusy = oBusy | r_stage[s].valid;
        end
    end

endmodule

// File: rtl/cos_lut_arbiter.sv
// Round-robin arbiter with burst hold sharing one cosine LUT evaluator among NREQ requesters.
// Define COS_ARB_STATS_EN to add per-requester saturating grant counters (oGrant_cnt, iStat_clr).
module cos_lut_arbiter
    import cos_lut_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int LAT       = 1,
    parameter int MAX_BURST = 4
)(
    input  logic               iClk,
    input  logic               iRst,
    input  logic [NREQ-1:0]    iReq_valid,
    input  logic [NREQ*XW-1:0] iReq_x,
    output logic [NREQ-1:0]    oReq_ready,
    output logic [XW-1:0]      oLut_x,
    input  logic [YW-1:0]      iLut_y,
    output logic [NREQ-1:0]    oRsp_valid,
    output logic [YW-1:0]      oRsp_y,
    output logic               oBusy
`ifdef COS_ARB_STATS_EN
    ,
    input  logic               iStat_clr,
    output logic [NREQ*16-1:0] oGrant_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    arbState_t       r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic [BW-1:0]   r_burst;

    logic            w_grant;
    logic [IW-1:0]   w_gid;
    logic            w_othersValid;
    logic            w_keep;
    logic [2*NREQ-1:0] w_dbl;
    logic [IW:0]     w_sum;
    logic [NREQ-1:0] w_hit;

    // Owner keeps the grant unless it drops valid or its burst is spent while others wait;
    // otherwise the valid vector is rotated by the pointer and the lowest rotated index wins.
    always_comb begin
        w_othersValid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if ((IW'(k) != r_owner) && iReq_valid[k]) w_othersValid = 1'b1;
        end
        w_keep = (r_state == HOLD) && iReq_valid[r_owner] &&
                 ((r_burst < BW'(MAX_BURST)) || !w_othersValid);
        w_dbl   = {iReq_valid, iReq_valid} >> r_ptr;
        w_sum   = '0;
        w_grant = 1'b0;
        w_gid   = r_owner;
        if (w_keep) begin
            w_grant = 1'b1;
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (w_dbl[i]) begin
                    w_grant = 1'b1;
                    w_sum   = {1'b0, r_ptr} + (IW+1)'(i);
                    w_gid   = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
                end
            end
        end
    end

    always_comb begin
        oReq_ready = '0;
        oLut_x     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant && (w_gid == IW'(k))) begin
                oReq_ready[k] = 1'b1;
                oLut_x        = iReq_x[k*XW +: XW];
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
        end else if (w_grant) begin
            r_state <= HOLD;
            r_owner <= w_gid;
            r_ptr   <= (w_gid == IW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
            if ((r_state == HOLD) && (w_gid == r_owner)) begin
                r_burst <= (r_burst == BW'(MAX_BURST)) ? r_burst : r_burst + 1'b1;
            end else begin
                r_burst <= BW'(1);
            end
        end else begin
            r_state <= IDLE;
            r_burst <= '0;
        end
    end

    cos_lut_tag_pipe #(
        .LAT  (LAT),
        .NREQ (NREQ)
    ) u_tagPipe (
        .iClk        (iClk),
        .iRst        (iRst),
        .iLoad_valid (w_grant),
        .iLoad_id    (ID_W'(w_gid)),
        .oHit        (w_hit),
        .oBusy       (oBusy)
    );

    assign oRsp_valid = w_hit;
    assign oRsp_y     = (|w_hit) ? iLut_y : '0;

`ifdef COS_ARB_STATS_EN
    logic [NREQ-1:0][15:0] r_grantCnt;

    // Clear wins over increment; counters stick at all-ones.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_grantCnt <= '0;
        end else if (iStat_clr) begin
            r_grantCnt <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (w_grant && (w_gid == IW'(k)) && (r_grantCnt[k] != 16'hFFFF)) begin
                    r_grantCnt[k] <= r_grantCnt[k] + 16'd1;
                end
            end
        end
    end

    assign oGrant_cnt = r_grantCnt;
`endif

endmodule
